control_sequencer: RTL and testbench
====================================

CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 SHALL have port Clock, input, 1 bit; single rising-edge clock for all state.
REQ-002 SHALL have port Reset, input, 1 bit; asynchronous, active-high reset.
REQ-003 SHALL have port Run, input, 1 bit; start/continue instruction execution.
REQ-004 SHALL have port IR, input, 32 bits; current instruction register value (opcode [31:27], Ra [26:23], Rb [22:19], Rc [18:15]).
REQ-005 SHALL have port MemReady, input, 1 bit; memory read data valid.
REQ-006 SHALL have outputs PCout, ZLOout, MDRout, each 1 bit; bus-drive selects.
REQ-007 SHALL have outputs MARin, Zin, PCin, MDRin, IRin, Yin, IncrementPC and Read, each 1 bit; load/strobe enables.
REQ-008 SHALL have output ALUControl, 5 bits; ALU operation code.
REQ-009 SHALL have outputs Rin and Rout, each 16 bits; one-hot register load and drive selects.
REQ-010 SHALL have output Halted, 1 bit; HALT instruction executed.
REQ-011 SHALL have output State, 4 bits; current state encoding, debug only.

Function
REQ-012 SHALL implement states IDLE, T0, T1, T2, T3, T4, T5, HALT (plus TRAP per REQ-027).
REQ-013 IDLE: all outputs 0; SHALL go to T0 on the next edge when Run=1, otherwise stay in IDLE.
REQ-014 T0: PCout=1, MARin=1, Zin=1; SHALL go to T1 unconditionally.
REQ-015 T1: ZLOout=1, Read=1, MDRin=1 for every T1 cycle; PCin=1 and IncrementPC=1 only in the first T1 cycle; SHALL stay in T1 while MemReady=0 and go to T2 on the first edge with MemReady=1.
REQ-016 T2: MDRout=1, IRin=1; SHALL go to T3.
REQ-017 T3, R-type opcode: Rout one-hot of Rb, Yin=1; SHALL go to T4.
REQ-018 T4: Rout one-hot of Rc, Zin=1, ALUControl=table[opcode]; SHALL go to T5.
REQ-019 T5: ZLOout=1, Rin one-hot of Ra; SHALL go to T0 if Run=1, otherwise to IDLE.
REQ-020 R-type opcode-to-ALU table: add 5'b00011->5'b00011, sub 5'b00100->5'b00100, and 5'b00101->5'b01011, or 5'b00110->5'b01010.
REQ-021 T3, HALT opcode 5'b11011: all outputs 0; SHALL go to HALT.
REQ-022 HALT: Halted=1, all other outputs 0; SHALL be left only by Reset.
REQ-023 ALUControl SHALL be 0 in every state except T4; Rin and Rout SHALL be 0 except in the stated states.
REQ-024 In T3, T4 and T5 the IR fields SHALL be read combinationally from the IR port; IR is stable from T3 onward.
REQ-025 Deasserting Run mid-instruction SHALL NOT abort the instruction; the sequencer completes T5 and then enters IDLE.

Reset
REQ-026 Reset=1 SHALL immediately force state IDLE, the first-T1 flag to 0, and every output to 0, including from any mid-instruction state or a T1 wait.

Configuration
REQ-027 With macro CTRL_ILLEGAL_TRAP_EN defined, a non-R-type, non-HALT opcode in T3 SHALL go to state TRAP; TRAP drives output Illegal=1 (1 bit, present only when the macro is defined) and all other outputs 0, and is left only by Reset.
REQ-028 Without CTRL_ILLEGAL_TRAP_EN, such an opcode SHALL execute as a NOP: T3 outputs 0, then T0 if Run=1, otherwise IDLE.

Structure
REQ-029 A shared package SHALL hold the state enum, opcode constants, ALU code constants and the opcode-to-ALU table function.
REQ-030 A sub-module reg_select_decoder SHALL convert a 4-bit register field to a 16-bit one-hot vector; it is instantiated for Ra, Rb and Rc.

Verification
REQ-031 Reset, Run=1, IR=0x28918000 (and R1,R2,R3), MemReady=1 -> T0..T5 in 6 cycles; T3 Rout=0x0004, Yin=1; T4 Rout=0x0008, ALUControl=5'b01011, Zin=1; T5 Rin=0x0002, ZLOout=1.
REQ-032 MemReady held 0 for 3 cycles in T1 -> T1 lasts 4 cycles; PCin and IncrementPC high only in the first; Read and MDRin high in all 4.
REQ-033 IR opcode 5'b11011 -> HALT after T3; Halted=1 held for 20 cycles regardless of Run; Reset returns to IDLE.
REQ-034 Run dropped during T4 -> T5 completes, then IDLE with all outputs 0; Run reasserted -> T0 on the next edge.
REQ-035 Reset asserted mid-T4 -> asynchronously, before the next edge, all outputs 0 and State=IDLE.
REQ-036 Opcode 5'b11111 -> TRAP with Illegal=1 when CTRL_ILLEGAL_TRAP_EN is defined; NOP then T0 when it is not.

Source files
------------

// File: rtl/control_sequencer_pkg.sv
// control_sequencer_pkg
//   Shared definitions for the control sequencer: the state encoding (also
//   visible on the State debug output), R-type and HALT opcode constants,
//   ALU operation codes and the opcode-to-ALU translation function.
//   The optional illegal-opcode trap is enabled by defining
//   CTRL_ILLEGAL_TRAP_EN; ST_TRAP is always declared so the encoding stays
//   identical between builds.
package control_sequencer_pkg;

  typedef enum logic [3:0] {
    ST_IDLE = 4'd0,
    ST_T0   = 4'd1,
    ST_T1   = 4'd2,
    ST_T2   = 4'd3,
    ST_T3   = 4'd4,
    ST_T4   = 4'd5,
    ST_T5   = 4'd6,
    ST_HALT = 4'd7,
    ST_TRAP = 4'd8
  } state_e;

  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_HALT = 5'b11011;

  localparam logic [4:0] ALU_NONE = 5'b00000;
  localparam logic [4:0] ALU_ADD  = 5'b00011;
  localparam logic [4:0] ALU_SUB  = 5'b00100;
  localparam logic [4:0] ALU_AND  = 5'b01011;
  localparam logic [4:0] ALU_OR   = 5'b01010;

  function automatic logic is_rtype(input logic [4:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) || (op == OP_OR);
  endfunction

  function automatic logic [4:0] alu_for_opcode(input logic [4:0] op);
    logic [4:0] code;
    case (op)
      OP_ADD:  code = ALU_ADD;
      OP_SUB:  code = ALU_SUB;
      OP_AND:  code = ALU_AND;
      OP_OR:   code = ALU_OR;
      default: code = ALU_NONE;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/control_sequencer_if.sv
// control_sequencer_if
//   Bundles the sequencer's instruction/memory inputs and all datapath
//   control outputs.
//   master : the sequencer (drives strobes, selects, Halted, State)
//   slave  : the datapath / memory side
//   Illegal exists only when CTRL_ILLEGAL_TRAP_EN is defined.
//
//   Memory handshake: Read is the request and is held high for every T1
//   cycle; MemReady acts as ready/valid for the read data. A transfer
//   completes on the first rising edge where Read=1 and MemReady=1, and
//   the sequencer leaves T1 on exactly that edge. MemReady is ignored in
//   every other state.
interface control_sequencer_if;
  logic        Run;
  logic [31:0] IR;
  logic        MemReady;

  logic        PCout, ZLOout, MDRout;
  logic        MARin, Zin, PCin, MDRin, IRin, Yin, IncrementPC, Read;
  logic [4:0]  ALUControl;
  logic [15:0] Rin, Rout;
  logic        Halted;
  logic [3:0]  State;
`ifdef CTRL_ILLEGAL_TRAP_EN
  logic        Illegal;
`endif

  modport master (
    input  Run, IR, MemReady,
`ifdef CTRL_ILLEGAL_TRAP_EN
    output Illegal,
`endif
    output PCout, ZLOout, MDRout, MARin, Zin, PCin, MDRin, IRin, Yin,
           IncrementPC, Read, ALUControl, Rin, Rout, Halted, State
  );

  modport slave (
    output Run, IR, MemReady,
`ifdef CTRL_ILLEGAL_TRAP_EN
    input  Illegal,
`endif
    input  PCout, ZLOout, MDRout, MARin, Zin, PCin, MDRin, IRin, Yin,
           IncrementPC, Read, ALUControl, Rin, Rout, Halted, State
  );
endinterface

// File: rtl/control_sequencer_reg_select_decoder.sv
// reg_select_decoder
//   Converts a 4-bit register field into a 16-bit one-hot select.
//   field_i  : register number 0..15
//   onehot_o : bit field_i set, all others clear
module reg_select_decoder (
  input  logic [3:0]  field_i,
  output logic [15:0] onehot_o
);
  assign onehot_o = 16'd1 << field_i;
endmodule

// File: rtl/control_sequencer.sv
// control_sequencer
//   Multi-cycle control FSM: fetch (T0-T2), R-type execute (T3-T5), HALT,
//   and an optional illegal-opcode TRAP (macro CTRL_ILLEGAL_TRAP_EN).
//   Ports:
//     Clock : rising-edge clock
//     Reset : asynchronous, active-high; forces IDLE and all outputs low
//     bus   : control_sequencer_if.master (Run, IR, MemReady in; all
//             control strobes, register selects, Halted, State out)
//   Outputs are purely decoded from the current state (plus IR fields in
//   T3-T5), so asserting Reset clears them without waiting for an edge.
module control_sequencer
  import control_sequencer_pkg::*;
(
  input  logic                 Clock,
  input  logic                 Reset,
  control_sequencer_if.master  bus
);

  state_e      state_q, state_d;
  logic        first_t1_q, first_t1_d;
  logic [4:0]  opcode;
  logic [15:0] ra_onehot, rb_onehot, rc_onehot;
  logic        unused_ir_low;

  // IR is stable from T3 onward, so fields are decoded straight from the port.
  assign opcode        = bus.IR[31:27];
  assign unused_ir_low = ^bus.IR[14:0];

  reg_select_decoder u_ra_dec (.field_i(bus.IR[26:23]), .onehot_o(ra_onehot));
  reg_select_decoder u_rb_dec (.field_i(bus.IR[22:19]), .onehot_o(rb_onehot));
  reg_select_decoder u_rc_dec (.field_i(bus.IR[18:15]), .onehot_o(rc_onehot));

  assign bus.State = state_q;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q    <= ST_IDLE;
      first_t1_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      first_t1_q <= first_t1_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    // T1 is only ever entered from T0, so this marks its first cycle;
    // PC increment must not repeat while waiting on memory.
    first_t1_d      = (state_q == ST_T0);
    bus.PCout       = 1'b0;
    bus.ZLOout      = 1'b0;
    bus.MDRout      = 1'b0;
    bus.MARin       = 1'b0;
    bus.Zin         = 1'b0;
    bus.PCin        = 1'b0;
    bus.MDRin       = 1'b0;
    bus.IRin        = 1'b0;
    bus.Yin         = 1'b0;
    bus.IncrementPC = 1'b0;
    bus.Read        = 1'b0;
    bus.ALUControl  = ALU_NONE;
    bus.Rin         = '0;
    bus.Rout        = '0;
    bus.Halted      = 1'b0;
`ifdef CTRL_ILLEGAL_TRAP_EN
    bus.Illegal     = 1'b0;
`endif

    case (state_q)
      ST_IDLE: if (bus.Run) state_d = ST_T0;
      ST_T0: begin
        bus.PCout = 1'b1;
        bus.MARin = 1'b1;
        bus.Zin   = 1'b1;
        state_d   = ST_T1;
      end
      ST_T1: begin
        bus.ZLOout      = 1'b1;
        bus.Read        = 1'b1;
        bus.MDRin       = 1'b1;
        bus.PCin        = first_t1_q;
        bus.IncrementPC = first_t1_q;
        if (bus.MemReady) state_d = ST_T2;
      end
      ST_T2: begin
        bus.MDRout = 1'b1;
        bus.IRin   = 1'b1;
        state_d    = ST_T3;
      end
      ST_T3: begin
        if (is_rtype(opcode)) begin
          bus.Rout = rb_onehot;
          bus.Yin  = 1'b1;
          state_d  = ST_T4;
        end else if (opcode == OP_HALT) begin
          state_d = ST_HALT;
        end else begin
`ifdef CTRL_ILLEGAL_TRAP_EN
          state_d = ST_TRAP;
`else
          // Unknown opcode retires as a NOP.
          state_d = bus.Run ? ST_T0 : ST_IDLE;
`endif
        end
      end
      ST_T4: begin
        bus.Rout       = rc_onehot;
        bus.Zin        = 1'b1;
        bus.ALUControl = alu_for_opcode(opcode);
        state_d        = ST_T5;
      end
      ST_T5: begin
        bus.ZLOout = 1'b1;
        bus.Rin    = ra_onehot;
        // Run is only consulted at instruction boundaries.
        state_d    = bus.Run ? ST_T0 : ST_IDLE;
      end
      ST_HALT: bus.Halted = 1'b1;
`ifdef CTRL_ILLEGAL_TRAP_EN
      ST_TRAP: bus.Illegal = 1'b1;
`endif
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer
//   Directed bench for control_sequencer. A phase-level reference model
//   tracks which step of the instruction the sequencer must be in and
//   derives every expected output from the instruction fields; a compare
//   process checks all outputs on each falling edge. Directed steps add
//   hand-computed literal checks. Define CTRL_ILLEGAL_TRAP_EN for the trap build.
module tb_control_sequencer;
  import control_sequencer_pkg::*;

  // ---------------- clock / reset ----------------
  logic Clock = 1'b0;
  logic Reset = 1'b1;
  always #5 Clock = ~Clock;

  control_sequencer_if bus ();

  control_sequencer dut (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus.master)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  localparam int P_IDLE = 0, P_T0 = 1, P_T1 = 2, P_T2 = 3, P_T3 = 4,
                 P_T4 = 5, P_T5 = 6, P_HALT = 7, P_TRAP = 8;

  int m_phase = P_IDLE;
  int m_t1_n  = 0;     // cycles already spent waiting in T1

  function automatic logic [4:0] ref_alu(input logic [4:0] op);
    case (op)
      5'b00011: return 5'b00011;
      5'b00100: return 5'b00100;
      5'b00101: return 5'b01011;
      5'b00110: return 5'b01010;
      default:  return 5'b00000;
    endcase
  endfunction

  function automatic bit ref_rtype(input logic [4:0] op);
    return (op >= 5'd3) && (op <= 5'd6);
  endfunction

  always @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      m_phase = P_IDLE;
      m_t1_n  = 0;
    end else begin
      case (m_phase)
        P_IDLE: if (bus.Run) m_phase = P_T0;
        P_T0:   begin m_phase = P_T1; m_t1_n = 0; end
        P_T1:   if (bus.MemReady) m_phase = P_T2; else m_t1_n++;
        P_T2:   m_phase = P_T3;
        P_T3: begin
          if (ref_rtype(bus.IR[31:27]))     m_phase = P_T4;
          else if (bus.IR[31:27] == 5'd27)  m_phase = P_HALT;
          else begin
`ifdef CTRL_ILLEGAL_TRAP_EN
            m_phase = P_TRAP;
`else
            m_phase = bus.Run ? P_T0 : P_IDLE;
`endif
          end
        end
        P_T4:   m_phase = P_T5;
        P_T5:   m_phase = bus.Run ? P_T0 : P_IDLE;
        default: ;
      endcase
    end
  end

  // ---------------- scoreboard compare ----------------
  always @(negedge Clock) begin : cmp
    logic [4:0]  op;
    logic [15:0] e_rin, e_rout;
    logic [4:0]  e_alu;
    logic [3:0]  e_state;
    logic e_pcout, e_zlo, e_mdrout, e_marin, e_zin, e_pcin, e_mdrin, e_irin;
    logic e_yin, e_inc, e_read, e_halt, e_ill;
    op = bus.IR[31:27];
    {e_pcout, e_zlo, e_mdrout, e_marin, e_zin, e_pcin, e_mdrin, e_irin} = '0;
    {e_yin, e_inc, e_read, e_halt, e_ill} = '0;
    e_rin = '0; e_rout = '0; e_alu = '0;
    case (m_phase)
      P_T0: begin e_pcout = 1; e_marin = 1; e_zin = 1; e_state = ST_T0; end
      P_T1: begin
        e_zlo = 1; e_read = 1; e_mdrin = 1;
        e_pcin = (m_t1_n == 0); e_inc = (m_t1_n == 0); e_state = ST_T1;
      end
      P_T2: begin e_mdrout = 1; e_irin = 1; e_state = ST_T2; end
      P_T3: begin
        e_state = ST_T3;
        if (ref_rtype(op)) begin e_rout = 16'd1 << bus.IR[22:19]; e_yin = 1; end
      end
      P_T4: begin
        e_rout = 16'd1 << bus.IR[18:15]; e_zin = 1; e_alu = ref_alu(op); e_state = ST_T4;
      end
      P_T5:   begin e_zlo = 1; e_rin = 16'd1 << bus.IR[26:23]; e_state = ST_T5; end
      P_HALT: begin e_halt = 1; e_state = ST_HALT; end
      P_TRAP: begin e_ill = 1; e_state = ST_TRAP; end
      default: e_state = ST_IDLE;
    endcase
    check("sb_State",       32'(bus.State),       32'(e_state));
    check("sb_PCout",       32'(bus.PCout),       32'(e_pcout));
    check("sb_ZLOout",      32'(bus.ZLOout),      32'(e_zlo));
    check("sb_MDRout",      32'(bus.MDRout),      32'(e_mdrout));
    check("sb_MARin",       32'(bus.MARin),       32'(e_marin));
    check("sb_Zin",         32'(bus.Zin),         32'(e_zin));
    check("sb_PCin",        32'(bus.PCin),        32'(e_pcin));
    check("sb_MDRin",       32'(bus.MDRin),       32'(e_mdrin));
    check("sb_IRin",        32'(bus.IRin),        32'(e_irin));
    check("sb_Yin",         32'(bus.Yin),         32'(e_yin));
    check("sb_IncrementPC", 32'(bus.IncrementPC), 32'(e_inc));
    check("sb_Read",        32'(bus.Read),        32'(e_read));
    check("sb_ALUControl",  32'(bus.ALUControl),  32'(e_alu));
    check("sb_Rin",         32'(bus.Rin),         32'(e_rin));
    check("sb_Rout",        32'(bus.Rout),        32'(e_rout));
    check("sb_Halted",      32'(bus.Halted),      32'(e_halt));
`ifdef CTRL_ILLEGAL_TRAP_EN
    check("sb_Illegal",     32'(bus.Illegal),     32'(e_ill));
`endif
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge Clock);
    #2;
  endtask

  function automatic logic [31:0] mk_ir(input logic [4:0] op, input logic [3:0] ra,
                                        input logic [3:0] rb, input logic [3:0] rc);
    return {op, ra, rb, rc, 15'h5a5a};
  endfunction

  // Starts from IDLE or T5 with Run=1, ends in T5 of the given instruction.
  task automatic exec(input logic [31:0] ir, input int mem_wait);
    bus.IR       = ir;
    bus.Run      = 1'b1;
    bus.MemReady = (mem_wait == 0);
    tick();                              // T0
    tick();                              // T1, first cycle
    for (int i = 0; i < mem_wait; i++) tick();
    bus.MemReady = 1'b1;
    repeat (4) tick();                   // T2, T3, T4, T5
  endtask

  function automatic logic [31:0] all_strobes();
    return {bus.PCout, bus.ZLOout, bus.MDRout, bus.MARin, bus.Zin, bus.PCin,
            bus.MDRin, bus.IRin, bus.Yin, bus.IncrementPC, bus.Read, bus.Halted,
            15'(bus.ALUControl), 5'd0} | 32'(bus.Rin) | 32'(bus.Rout);
  endfunction

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------- directed stimulus ----------------
  initial begin
    bus.Run = 1'b0; bus.IR = 32'h0; bus.MemReady = 1'b1;
    tick(); tick();
    check("reset_state",   32'(bus.State), 32'd0);
    check("reset_outputs", all_strobes(),  32'd0);
    Reset = 1'b0;
    tick();
    check("idle_no_run", 32'(bus.State), 32'(ST_IDLE));

    // AND R1,R2,R3 with immediate memory; Run dropped in T4.
    bus.IR = 32'h28918000; bus.Run = 1'b1;
    tick(); check("t0_pcout", 32'(bus.PCout), 32'd1);
    tick(); check("t1_pcin",  32'(bus.PCin),  32'd1);
            check("t1_read",  32'(bus.Read),  32'd1);
    tick(); check("t2_irin",  32'(bus.IRin),  32'd1);
    tick(); check("t3_rout",  32'(bus.Rout),  32'h0004);
            check("t3_yin",   32'(bus.Yin),   32'd1);
    tick(); check("t4_rout",  32'(bus.Rout),  32'h0008);
            check("t4_alu",   32'(bus.ALUControl), 32'b01011);
            check("t4_zin",   32'(bus.Zin),   32'd1);
    bus.Run = 1'b0;
    tick(); check("t5_rin",   32'(bus.Rin),   32'h0002);
            check("t5_zlo",   32'(bus.ZLOout), 32'd1);
    tick(); check("drop_idle_state", 32'(bus.State), 32'(ST_IDLE));
            check("drop_idle_outs",  all_strobes(),  32'd0);
    tick(); check("idle_hold", 32'(bus.State), 32'(ST_IDLE));
    bus.Run = 1'b1;
    tick(); check("rerun_t0", 32'(bus.State), 32'(ST_T0));
    repeat (5) tick();                   // finish the instruction, now in T5

    // Memory wait: MemReady low for three T1 cycles.
    bus.IR = mk_ir(5'b00011, 4'd4, 4'd5, 4'd6); bus.MemReady = 1'b0;
    tick();                              // T0
    tick(); check("w1_pcin", 32'(bus.PCin), 32'd1);
            check("w1_inc",  32'(bus.IncrementPC), 32'd1);
    tick(); check("w2_pcin", 32'(bus.PCin), 32'd0);
            check("w2_read", 32'(bus.Read), 32'd1);
    tick(); check("w3_state", 32'(bus.State), 32'(ST_T1));
    tick(); check("w4_state", 32'(bus.State), 32'(ST_T1));
            check("w4_mdrin", 32'(bus.MDRin), 32'd1);
            check("w4_inc",   32'(bus.IncrementPC), 32'd0);
    bus.MemReady = 1'b1;
    tick(); check("w_t2", 32'(bus.State), 32'(ST_T2));
    repeat (3) tick();                   // T3, T4, T5

    // Further R-type patterns including register boundaries.
    exec(mk_ir(5'b00100, 4'd15, 4'd0,  4'd7), 1);
    check("sub_t5_rin", 32'(bus.Rin), 32'h8000);
    exec(mk_ir(5'b00110, 4'd0,  4'd15, 4'd8), 2);
    check("or_t5_rin", 32'(bus.Rin), 32'h0001);
    exec(mk_ir(5'b00011, 4'd9,  4'd9,  4'd9), 0);

    // Asynchronous reset in the middle of T4.
    bus.IR = mk_ir(5'b00101, 4'd1, 4'd2, 4'd3);
    repeat (5) tick();                   // T0..T4
    check("pre_rst_t4", 32'(bus.State), 32'(ST_T4));
    #1 Reset = 1'b1;
    #1;
    check("async_rst_state", 32'(bus.State), 32'd0);
    check("async_rst_outs",  all_strobes(),  32'd0);
    tick(); Reset = 1'b0; bus.Run = 1'b1;

    // Undefined opcode 5'b11111.
    bus.IR = 32'hF8000000;
    repeat (4) tick();                   // T0..T3
    check("illegal_t3_outs", all_strobes(), 32'd0);
    tick();
`ifdef CTRL_ILLEGAL_TRAP_EN
    check("trap_state",   32'(bus.State),   32'(ST_TRAP));
    check("trap_illegal", 32'(bus.Illegal), 32'd1);
    bus.Run = 1'b0; repeat (3) tick();
    check("trap_hold", 32'(bus.State), 32'(ST_TRAP));
`else
    check("nop_to_t0", 32'(bus.State), 32'(ST_T0));
    bus.Run = 1'b0; repeat (4) tick();   // T1, T2, T3, IDLE
    check("nop_to_idle", 32'(bus.State), 32'(ST_IDLE));
`endif
    Reset = 1'b1; tick(); Reset = 1'b0;

    // HALT.
    bus.IR = 32'hD8000000; bus.Run = 1'b1;
    repeat (4) tick();                   // T0..T3
    check("halt_t3_outs", all_strobes(), 32'd0);
    tick();
    check("halt_state", 32'(bus.State), 32'(ST_HALT));
    for (int i = 0; i < 20; i++) begin
      bus.Run = i[0];
      tick();
      check("halt_held", 32'(bus.Halted), 32'd1);
    end
    Reset = 1'b1;
    #1;
    check("halt_rst_state",  32'(bus.State),  32'd0);
    check("halt_rst_halted", 32'(bus.Halted), 32'd0);
    tick(); Reset = 1'b0; bus.Run = 1'b0;
    tick();
    check("final_idle", 32'(bus.State), 32'(ST_IDLE));

    @(negedge Clock);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
